// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
// Holds FSM states, owner encoding and the strobe-width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

    function automatic int strb_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-macro signals of the shared memory port.
// master = requesters plus memory model, slave = the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import mem_arb_pkg::*;

    localparam int SW = strb_width(DATA_WIDTH);

    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_resp_valid;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  dm_req_valid;
    logic                  dm_req_ready;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic                  dm_we;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic [SW-1:0]         dm_wstrb;
    logic                  dm_resp_valid;
    logic [DATA_WIDTH-1:0] dm_rdata;
    logic                  mem_en;
    logic [SW-1:0]         mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  busy;

    modport master (
        output if_req_valid, if_addr,
        output dm_req_valid, dm_addr, dm_we, dm_wdata, dm_wstrb,
        output mem_rdata,
        input  if_req_ready, if_resp_valid, if_rdata,
        input  dm_req_ready, dm_resp_valid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
        input  if_req_valid, if_addr,
        input  dm_req_valid, dm_addr, dm_we, dm_wdata, dm_wstrb,
        input  mem_rdata,
        output if_req_ready, if_resp_valid, if_rdata,
        output dm_req_ready, dm_resp_valid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mem_arb_prio.sv
// Grant selection for the shared port: data wins unless fetch is starved.
// Purely combinational; the starvation counter lives in the parent.
module mem_arb_prio (
    input  logic win_i,
    input  logic if_valid_i,
    input  logic dm_valid_i,
    input  logic starved_i,
    output logic if_gnt_o,
    output logic dm_gnt_o
);

    // At most one grant, only inside the accept window.
    always_comb begin
        if_gnt_o = 1'b0;
        dm_gnt_o = 1'b0;
        unique case (1'b1)
            (win_i && if_valid_i && (!dm_valid_i || starved_i)):
                if_gnt_o = 1'b1;
            (win_i && dm_valid_i && !(if_valid_i && starved_i)):
                dm_gnt_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (read) and load/store.
// Optional MEM_PORT_ARB_PERF_EN adds grant and conflict counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MEM_PORT_ARB_PERF_EN
    output logic [31:0] perf_if_grants,
    output logic [31:0] perf_dm_grants,
    output logic [31:0] perf_conflict_cycles,
`endif
    mem_port_arbiter_if.slave bus
);

    localparam int SW = strb_width(DATA_WIDTH);
    localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [LW-1:0] LAT_LOAD = LW'(MEM_LATENCY - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STARVE_LIMIT);

    arb_state_e            state_q, state_d;
    arb_owner_e            owner_q, owner_d;
    logic                  we_q, we_d;
    logic [LW-1:0]         lat_q, lat_d;
    logic [CW-1:0]         starve_q, starve_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
    logic                  win, if_gnt, dm_gnt, to_resp;

    assign win = (state_q == IDLE) || (state_q == RESP);

    mem_arb_prio u_prio (
        .win_i      (win),
        .if_valid_i (bus.if_req_valid),
        .dm_valid_i (bus.dm_req_valid),
        .starved_i  (starve_q == CNT_MAX),
        .if_gnt_o   (if_gnt),
        .dm_gnt_o   (dm_gnt)
    );

    // Next-state, issue-side memory drive and response capture.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        we_d          = we_q;
        lat_d         = lat_q;
        starve_d      = starve_q;
        if_rdata_d    = if_rdata_q;
        dm_rdata_d    = dm_rdata_q;
        to_resp       = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state_q)
            IDLE, RESP: begin
                if (!bus.if_req_valid) starve_d = '0;
                if (if_gnt) begin
                    starve_d     = '0;
                    owner_d      = OWN_IF;
                    we_d         = 1'b0;
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = bus.if_addr;
                end else if (dm_gnt) begin
                    if (bus.if_req_valid && starve_q != CNT_MAX)
                        starve_d = starve_q + 1'b1;
                    owner_d       = OWN_DM;
                    we_d          = bus.dm_we;
                    bus.mem_en    = 1'b1;
                    bus.mem_addr  = bus.dm_addr;
                    bus.mem_wdata = bus.dm_wdata;
                    bus.mem_we    = bus.dm_we ? bus.dm_wstrb : '0;
                end
                if (if_gnt || dm_gnt) begin
                    lat_d = LAT_LOAD;
                    if (MEM_LATENCY == 1) begin
                        state_d = RESP;
                        to_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                lat_d = lat_q - 1'b1;
                if (lat_q == LW'(1)) begin
                    state_d = RESP;
                    to_resp = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (to_resp) begin
            if (owner_d == OWN_IF) if_rdata_d = bus.mem_rdata;
            else dm_rdata_d = we_d ? '0 : bus.mem_rdata;
        end
    end

    // State, owner, counters and captured read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_DM;
            we_q       <= 1'b0;
            lat_q      <= '0;
            starve_q   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            lat_q      <= lat_d;
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign bus.if_req_ready  = if_gnt;
    assign bus.dm_req_ready  = dm_gnt;
    assign bus.if_resp_valid = (state_q == RESP) && (owner_q == OWN_IF);
    assign bus.dm_resp_valid = (state_q == RESP) && (owner_q == OWN_DM);
    assign bus.if_rdata      = if_rdata_q;
    assign bus.dm_rdata      = dm_rdata_q;
    assign bus.busy          = (state_q != IDLE);

`ifdef MEM_PORT_ARB_PERF_EN
    logic [31:0] pif_q, pdm_q, pcf_q;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            pif_q <= '0;
            pdm_q <= '0;
            pcf_q <= '0;
        end else begin
            if (if_gnt) pif_q <= pif_q + 32'd1;
            if (dm_gnt) pdm_q <= pdm_q + 32'd1;
            if (bus.if_req_valid && bus.dm_req_valid)
                pcf_q <= pcf_q + 32'd1;
        end
    end

    assign perf_if_grants       = pif_q;
    assign perf_dm_grants       = pdm_q;
    assign perf_conflict_cycles = pcf_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: per-cycle vector table on a latency-1 arbiter,
// plus hand sequences on a latency-3 arbiter.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst1 = 1'b1;
    logic rst3 = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();
    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b3 ();

`ifdef MEM_PORT_ARB_PERF_EN
    logic [31:0] p1i, p1d, p1c, p3i, p3d, p3c;
`endif

    mem_port_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .MEM_LATENCY(1), .STARVE_LIMIT(4)
    ) u_l1 (
        .clk(clk),
        .rst(rst1),
`ifdef MEM_PORT_ARB_PERF_EN
        .perf_if_grants(p1i),
        .perf_dm_grants(p1d),
        .perf_conflict_cycles(p1c),
`endif
        .bus(b1)
    );

    mem_port_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .MEM_LATENCY(3), .STARVE_LIMIT(4)
    ) u_l3 (
        .clk(clk),
        .rst(rst3),
`ifdef MEM_PORT_ARB_PERF_EN
        .perf_if_grants(p3i),
        .perf_dm_grants(p3d),
        .perf_conflict_cycles(p3c),
`endif
        .bus(b3)
    );

    typedef struct {
        logic [31:0] ifv, ifa, dmv, dwe, dma, dwd, dws, mrd;
        logic [31:0] ifr, dmr, en, we, ma, mwd, busy;
        logic [31:0] ifrv, ifrd, dmrv, dmrd;
    } vec_t;

    vec_t vt[32];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive1(input vec_t v);
        b1.if_req_valid = v.ifv[0];
        b1.if_addr      = v.ifa;
        b1.dm_req_valid = v.dmv[0];
        b1.dm_we        = v.dwe[0];
        b1.dm_addr      = v.dma;
        b1.dm_wdata     = v.dwd;
        b1.dm_wstrb     = v.dws[3:0];
        b1.mem_rdata    = v.mrd;
    endtask

    task automatic check1(input int i, input vec_t v);
        string p;
        p = $sformatf("v%0d.", i);
        chk({p, "if_req_ready"},  32'(b1.if_req_ready),  v.ifr);
        chk({p, "dm_req_ready"},  32'(b1.dm_req_ready),  v.dmr);
        chk({p, "mem_en"},        32'(b1.mem_en),        v.en);
        chk({p, "mem_we"},        32'(b1.mem_we),        v.we);
        chk({p, "mem_addr"},      b1.mem_addr,           v.ma);
        chk({p, "mem_wdata"},     b1.mem_wdata,          v.mwd);
        chk({p, "busy"},          32'(b1.busy),          v.busy);
        chk({p, "if_resp_valid"}, 32'(b1.if_resp_valid), v.ifrv);
        chk({p, "if_rdata"},      b1.if_rdata,           v.ifrd);
        chk({p, "dm_resp_valid"}, 32'(b1.dm_resp_valid), v.dmrv);
        chk({p, "dm_rdata"},      b1.dm_rdata,           v.dmrd);
    endtask

    task automatic idle3();
        b3.if_req_valid = 1'b0;
        b3.if_addr      = '0;
        b3.dm_req_valid = 1'b0;
        b3.dm_we        = 1'b0;
        b3.dm_addr      = '0;
        b3.dm_wdata     = '0;
        b3.dm_wstrb     = '0;
        b3.mem_rdata    = '0;
    endtask

    initial begin
        logic [9:0] en_b, rdy_b, rv_b, bz_b;
        logic [4:0] ifrv_b;
        logic [31:0] rd3;
        // ifv ifa dmv dwe dma dwd dws mrd | ifr dmr en we ma mwd busy ifrv ifrd dmrv dmrd
        vt[0]  = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0};
        vt[1]  = '{1,'h100,0,0,0,0,0,'h13, 1,0,1,0,'h100,0,0,0,0,0,0};
        vt[2]  = '{0,0,0,0,0,0,0,'h13, 0,0,0,0,0,0,1,1,'h13,0,0};
        vt[3]  = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,'h13,0,0};
        vt[4]  = '{0,0,1,1,'h2004,'hDEADBEEF,'hC,'h55555555,
                   0,1,1,'hC,'h2004,'hDEADBEEF,0,0,'h13,0,0};
        vt[5]  = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,'h13,1,0};
        vt[6]  = '{0,0,1,0,'h3000,0,0,'hCAFEF00D,
                   0,1,1,0,'h3000,0,0,0,'h13,0,0};
        vt[7]  = '{0,0,1,0,'h3004,0,0,'h12345678,
                   0,1,1,0,'h3004,0,1,0,'h13,1,'hCAFEF00D};
        vt[8]  = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,'h13,1,'h12345678};
        vt[9]  = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,'h13,0,'h12345678};
        vt[10] = '{1,'h200,1,0,'h4000,0,0,'hA0000001,
                   0,1,1,0,'h4000,0,0,0,'h13,0,'h12345678};
        vt[11] = '{1,'h200,1,0,'h4000,0,0,'hA0000002,
                   0,1,1,0,'h4000,0,1,0,'h13,1,'hA0000001};
        vt[12] = '{1,'h200,1,0,'h4000,0,0,'hA0000003,
                   0,1,1,0,'h4000,0,1,0,'h13,1,'hA0000002};
        vt[13] = '{1,'h200,1,0,'h4000,0,0,'hA0000004,
                   0,1,1,0,'h4000,0,1,0,'h13,1,'hA0000003};
        vt[14] = '{1,'h200,1,0,'h4000,0,0,'hB0000001,
                   1,0,1,0,'h200,0,1,0,'h13,1,'hA0000004};
        vt[15] = '{1,'h200,1,0,'h4000,0,0,'hA0000005,
                   0,1,1,0,'h4000,0,1,1,'hB0000001,0,'hA0000004};
        vt[16] = '{1,'h200,1,0,'h4000,0,0,'hA0000006,
                   0,1,1,0,'h4000,0,1,0,'hB0000001,1,'hA0000005};
        vt[17] = '{1,'h200,1,0,'h4000,0,0,'hA0000007,
                   0,1,1,0,'h4000,0,1,0,'hB0000001,1,'hA0000006};
        vt[18] = '{1,'h200,1,0,'h4000,0,0,'hA0000008,
                   0,1,1,0,'h4000,0,1,0,'hB0000001,1,'hA0000007};
        vt[19] = '{1,'h200,1,0,'h4000,0,0,'hB0000002,
                   1,0,1,0,'h200,0,1,0,'hB0000001,1,'hA0000008};
        vt[20] = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,1,'hB0000002,0,'hA0000008};
        vt[21] = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,'hB0000002,0,'hA0000008};
        vt[22] = '{1,'h200,1,0,'h4000,0,0,0,
                   0,1,1,0,'h4000,0,0,0,'hB0000002,0,'hA0000008};
        vt[23] = '{1,'h200,1,0,'h4000,0,0,0,
                   0,1,1,0,'h4000,0,1,0,'hB0000002,1,0};
        vt[24] = '{0,0,1,0,'h4000,0,0,0,
                   0,1,1,0,'h4000,0,1,0,'hB0000002,1,0};
        for (int k = 25; k < 29; k++)
            vt[k] = '{1,'h200,1,0,'h4000,0,0,0,
                      0,1,1,0,'h4000,0,1,0,'hB0000002,1,0};
        vt[29] = '{1,'h200,1,0,'h4000,0,0,0,
                   1,0,1,0,'h200,0,1,0,'hB0000002,1,0};
        vt[30] = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,1,0,0,0};
        vt[31] = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0};

        drive1(vt[0]);
        idle3();
        repeat (2) @(posedge clk);
        #1;
        rst1 = 1'b0;
        rst3 = 1'b0;

        for (int i = 0; i < 32; i++) begin
            drive1(vt[i]);
            @(negedge clk);
            check1(i, vt[i]);
            @(posedge clk);
            #1;
        end
        drive1(vt[0]);

`ifdef MEM_PORT_ARB_PERF_EN
        @(negedge clk);
        chk("perf_conflict_cycles", p1c, 32'd17);
        chk("perf_if_grants", p1i, 32'd4);
        chk("perf_dm_grants", p1d, 32'd18);
        @(posedge clk);
        #1;
`endif

        b3.dm_req_valid = 1'b1;
        b3.dm_addr      = 32'h800;
        b3.mem_rdata    = 32'h77;
        rd3 = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            en_b[c]  = b3.mem_en;
            rdy_b[c] = b3.dm_req_ready;
            rv_b[c]  = b3.dm_resp_valid;
            bz_b[c]  = b3.busy;
            if (c == 3) rd3 = b3.dm_rdata;
            @(posedge clk);
            #1;
        end
        b3.dm_req_valid = 1'b0;
        chk("l3.mem_en_pattern", 32'(en_b), 32'h249);
        chk("l3.dm_ready_pattern", 32'(rdy_b), 32'h249);
        chk("l3.dm_resp_pattern", 32'(rv_b), 32'h248);
        chk("l3.busy_pattern", 32'(bz_b), 32'h3FE);
        chk("l3.dm_rdata", rd3, 32'h77);
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("l3.drained_busy", 32'(b3.busy), 32'd0);

        @(posedge clk);
        #1;
        b3.if_req_valid = 1'b1;
        b3.if_addr      = 32'h900;
        b3.mem_rdata    = 32'h99;
        @(negedge clk);
        chk("rst.first_if_ready", 32'(b3.if_req_ready), 32'd1);
        @(posedge clk);
        #1;
        rst3 = 1'b1;
        @(negedge clk);
        chk("rst.wait_busy", 32'(b3.busy), 32'd1);
        @(posedge clk);
        #1;
        rst3 = 1'b0;
        @(negedge clk);
        chk("rst.after_busy", 32'(b3.busy), 32'd0);
        chk("rst.after_if_resp", 32'(b3.if_resp_valid), 32'd0);
        chk("rst.regrant_if_ready", 32'(b3.if_req_ready), 32'd1);
        chk("rst.regrant_mem_addr", b3.mem_addr, 32'h900);
        @(posedge clk);
        #1;
        b3.if_req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            ifrv_b[c] = b3.if_resp_valid;
            if (c == 2) rd3 = b3.if_rdata;
            @(posedge clk);
            #1;
        end
        chk("rst.if_resp_pattern", 32'(ifrv_b), 32'h4);
        chk("rst.if_rdata", rd3, 32'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
